// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding, port ids,
// RV32I load/store funct3 codes, the latched command layout and an access-size helper.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LW  = 3'd2;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;
  localparam logic [2:0] FUNCT3_SB  = 3'd0;
  localparam logic [2:0] FUNCT3_SH  = 3'd1;
  localparam logic [2:0] FUNCT3_SW  = 3'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [2:0]  funct3;
    logic        port;
    logic        err;
  } cmd_t;

  // Bytes touched by an access; funct3[1:0] encodes the width for loads and stores.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data_memory side of the arbiter.
// slave: arbiter view; master: requesters plus memory model view.
interface dmem_arbiter_if;
  logic        lsu_req_valid_i;
  logic        lsu_req_ready_o;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_funct3_i;
  logic        lsu_rsp_valid_o;
  logic [31:0] lsu_rsp_data_o;
  logic        lsu_rsp_err_o;

  logic        dma_req_valid_i;
  logic        dma_req_ready_o;
  logic [31:0] dma_addr_i;
  logic [31:0] dma_wdata_i;
  logic        dma_we_i;
  logic [2:0]  dma_funct3_i;
  logic        dma_rsp_valid_o;
  logic [31:0] dma_rsp_data_o;
  logic        dma_rsp_err_o;

  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_read_en_o;
  logic        mem_write_en_o;
  logic [2:0]  mem_funct3_o;
  logic [31:0] mem_read_data_i;

  modport slave (
    input  lsu_req_valid_i, lsu_addr_i, lsu_wdata_i, lsu_we_i, lsu_funct3_i,
    output lsu_req_ready_o, lsu_rsp_valid_o, lsu_rsp_data_o, lsu_rsp_err_o,
    input  dma_req_valid_i, dma_addr_i, dma_wdata_i, dma_we_i, dma_funct3_i,
    output dma_req_ready_o, dma_rsp_valid_o, dma_rsp_data_o, dma_rsp_err_o,
    output mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o, mem_funct3_o,
    input  mem_read_data_i
  );

  modport master (
    output lsu_req_valid_i, lsu_addr_i, lsu_wdata_i, lsu_we_i, lsu_funct3_i,
    input  lsu_req_ready_o, lsu_rsp_valid_o, lsu_rsp_data_o, lsu_rsp_err_o,
    output dma_req_valid_i, dma_addr_i, dma_wdata_i, dma_we_i, dma_funct3_i,
    input  dma_req_ready_o, dma_rsp_valid_o, dma_rsp_data_o, dma_rsp_err_o,
    input  mem_addr_o, mem_wdata_o, mem_read_en_o, mem_write_en_o, mem_funct3_o,
    output mem_read_data_i
  );
endinterface

// File: rtl/dmem_arbiter_access_check.sv
// Combinational legality screen for one request: funct3, alignment and bounds.
module dmem_access_check
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [2:0]  funct3,
  output logic        err
);

  logic [2:0]  size;
  logic [32:0] last_byte;
  logic        funct3_ok;
  logic        misaligned;
  logic        out_of_bounds;

  always_comb begin
    size          = access_size(funct3);
    // 33-bit sum so an access near 0xFFFF_FFFF cannot wrap back into range
    last_byte     = {1'b0, addr} + 33'(size) - 33'd1;
    out_of_bounds = last_byte >= 33'(MEM_BYTES);
    misaligned    = ((size == 3'd2) && addr[0]) ||
                    ((size == 3'd4) && (addr[1:0] != 2'b00));
    if (we) funct3_ok = funct3 inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW};
    else    funct3_ok = funct3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
    err = !funct3_ok || misaligned || out_of_bounds;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: one transaction in
// flight, accept -> issue -> one-cycle response, with DMA anti-starvation.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = 4096,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  state_t            state;
  cmd_t              cmd;
  logic [CNT_W-1:0]  starve_cnt;
  logic              lsu_rsp_valid, dma_rsp_valid;
  logic              lsu_rsp_err, dma_rsp_err;
  logic [31:0]       lsu_rsp_data, dma_rsp_data;

  logic              can_accept, dma_force, lsu_acc, dma_acc, accept;
  logic              issuing, req_err;
  logic [31:0]       req_addr, req_wdata, rsp_data_c;
  logic              req_we;
  logic [2:0]        req_funct3;

  // Grant depends only on state, starvation and the other port's valid.
  assign can_accept          = rst_n && ((state == IDLE) || (state == RESP));
  assign dma_force           = bus.dma_req_valid_i && (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign bus.lsu_req_ready_o = can_accept && !dma_force;
  assign bus.dma_req_ready_o = can_accept && (dma_force || !bus.lsu_req_valid_i);
  assign lsu_acc             = bus.lsu_req_valid_i && bus.lsu_req_ready_o;
  assign dma_acc             = bus.dma_req_valid_i && bus.dma_req_ready_o;
  assign accept              = lsu_acc || dma_acc;

  assign req_addr   = dma_acc ? bus.dma_addr_i   : bus.lsu_addr_i;
  assign req_wdata  = dma_acc ? bus.dma_wdata_i  : bus.lsu_wdata_i;
  assign req_we     = dma_acc ? bus.dma_we_i     : bus.lsu_we_i;
  assign req_funct3 = dma_acc ? bus.dma_funct3_i : bus.lsu_funct3_i;

  dmem_access_check #(.MEM_BYTES(MEM_BYTES)) u_check (
    .addr   (req_addr),
    .we     (req_we),
    .funct3 (req_funct3),
    .err    (req_err)
  );

  // Memory side is driven only during ISSUE; enables are also gated by reset.
  assign issuing            = (state == ISSUE);
  assign bus.mem_addr_o     = issuing ? cmd.addr   : 32'd0;
  assign bus.mem_wdata_o    = issuing ? cmd.wdata  : 32'd0;
  assign bus.mem_funct3_o   = issuing ? cmd.funct3 : 3'd0;
  assign bus.mem_read_en_o  = rst_n && issuing && !cmd.err && !cmd.we;
  assign bus.mem_write_en_o = rst_n && issuing && !cmd.err &&  cmd.we;
  assign rsp_data_c         = (cmd.err || cmd.we) ? 32'd0 : bus.mem_read_data_i;

  assign bus.lsu_rsp_valid_o = lsu_rsp_valid;
  assign bus.lsu_rsp_data_o  = lsu_rsp_data;
  assign bus.lsu_rsp_err_o   = lsu_rsp_err;
  assign bus.dma_rsp_valid_o = dma_rsp_valid;
  assign bus.dma_rsp_data_o  = dma_rsp_data;
  assign bus.dma_rsp_err_o   = dma_rsp_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cmd           <= '0;
      starve_cnt    <= '0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_err   <= 1'b0;
      lsu_rsp_data  <= 32'd0;
      dma_rsp_valid <= 1'b0;
      dma_rsp_err   <= 1'b0;
      dma_rsp_data  <= 32'd0;
    end else begin
      lsu_rsp_valid <= 1'b0;
      dma_rsp_valid <= 1'b0;

      if (!bus.dma_req_valid_i || dma_acc)
        starve_cnt <= '0;
      else if (lsu_acc && (starve_cnt != CNT_W'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + CNT_W'(1);

      if (accept)
        cmd <= '{addr: req_addr, wdata: req_wdata, we: req_we, funct3: req_funct3,
                 port: dma_acc ? PORT_DMA : PORT_LSU, err: req_err};

      case (state)
        IDLE:  if (accept) state <= ISSUE;
        ISSUE: begin
          state <= RESP;
          // Load data is captured at the same edge the store would commit.
          if (cmd.port == PORT_DMA) begin
            dma_rsp_valid <= 1'b1;
            dma_rsp_err   <= cmd.err;
            dma_rsp_data  <= rsp_data_c;
          end else begin
            lsu_rsp_valid <= 1'b1;
            lsu_rsp_err   <= cmd.err;
            lsu_rsp_data  <= rsp_data_c;
          end
        end
        RESP:    state <= accept ? ISSUE : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
